// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Shift-add multiply and restoring divide on magnitudes, sign fixed at the end.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             r_hsel;
    logic             r_rem;
    logic             r_neg_p;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_m;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag;

    logic             w_accept;
    logic             w_is_div;
    logic             w_sgn_a;
    logic             w_sgn_b;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_spec_res;

    logic [XLEN:0]    w_add;
    logic [XLEN:0]    w_shr;
    logic [XLEN:0]    w_dif;
    logic             w_qbit;
    logic [XLEN-1:0]  w_nhi;
    logic [XLEN-1:0]  w_nlo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]  w_mres;
    logic [XLEN-1:0]  w_quo;
    logic [XLEN-1:0]  w_rmd;
    logic [XLEN-1:0]  w_fres;

    // Request decode: signedness, magnitudes and RISC-V special cases
    always_comb begin
        w_is_div   = in_op[2];
        w_sgn_a    = in_op[2] ? !in_op[0] : (in_op[1:0] != 2'b11);
        w_sgn_b    = in_op[2] ? !in_op[0] : !in_op[1];
        w_neg_a    = w_sgn_a && in_a[XLEN-1];
        w_neg_b    = w_sgn_b && in_b[XLEN-1];
        w_mag_a    = w_neg_a ? (~in_a + 1'b1) : in_a;
        w_mag_b    = w_neg_b ? (~in_b + 1'b1) : in_b;
        w_b_zero   = (in_b == '0);
        w_ovf      = w_sgn_a && (in_a == MIN_NEG) && (in_b == '1);
        w_special  = w_is_div && (w_b_zero || w_ovf);
        w_spec_res = '1;
        if (in_op[1]) begin
            w_spec_res = w_b_zero ? in_a : '0;
        end else begin
            w_spec_res = w_b_zero ? '1 : in_a;
        end
        w_accept   = (r_state == S_IDLE) && in_valid && !kill;
    end

    // One iteration of shift-add or restoring divide, plus final sign fix
    always_comb begin
        w_add  = {1'b0, r_hi} + ({(XLEN+1){r_lo[0]}} & {1'b0, r_m});
        w_shr  = {r_hi, r_lo[XLEN-1]};
        w_dif  = w_shr - {1'b0, r_m};
        w_qbit = !w_dif[XLEN];
        if (r_div) begin
            w_nhi = w_qbit ? w_dif[XLEN-1:0] : w_shr[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], w_qbit};
        end else begin
            w_nhi = w_add[XLEN:1];
            w_nlo = {w_add[0], r_lo[XLEN-1:1]};
        end
        w_prod   = {w_nhi, w_nlo};
        w_prod_s = r_neg_p ? (~w_prod + 1'b1) : w_prod;
        w_mres   = r_hsel ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0];
        w_quo    = r_neg_p ? (~w_nlo + 1'b1) : w_nlo;
        w_rmd    = r_neg_r ? (~w_nhi + 1'b1) : w_nhi;
        if (r_div) begin
            w_fres = r_rem ? w_rmd : w_quo;
        end else begin
            w_fres = w_mres;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !kill) begin
                    w_state_nxt = w_special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (kill || out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_hsel   <= 1'b0;
            r_rem    <= 1'b0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_div   <= w_is_div;
            r_hsel  <= (in_op[1:0] != 2'b00);
            r_rem   <= in_op[1];
            r_neg_p <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_m     <= w_is_div ? w_mag_b : w_mag_a;
            r_lo    <= w_is_div ? w_mag_a : w_mag_b;
            r_hi    <= '0;
            r_tag   <= in_tag;
            if (w_special) begin
                r_result <= w_spec_res;
            end
        end else if (r_state == S_BUSY) begin
            if (kill) begin
                r_cnt <= '0;
            end else begin
                r_hi  <= w_nhi;
                r_lo  <= w_nlo;
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_result <= w_fres;
                end
            end
        end
    end

    assign out_result = r_result;
    assign out_tag    = r_tag;

endmodule
